// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester buffered arbiter.
// The arbitration choice lives here so every user makes the same pick.
package mux_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // A lone valid requester wins; on a tie the one not served last wins.
    function automatic logic pick_src(input logic a_v, input logic b_v, input logic last_src);
        logic src;
        if (a_v && b_v) begin
            src = ~last_src;
        end else if (b_v) begin
            src = SRC_B;
        end else begin
            src = SRC_A;
        end
        return src;
    endfunction

endpackage

// File: rtl/mux_arbiter_mux2.sv
// Parameterized 2:1 data multiplexer; sel_i = 0 passes d0_i, 1 passes d1_i.
module mux_arbiter_mux2 #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter feeding a one-word output buffer with valid/ready on
// every side; fair round-robin on ties, one word per cycle when unstalled.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [N-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [N-1:0] b_data,
    output logic         b_ready,
    output logic         y_valid,
    output logic [N-1:0] y,
    output logic         y_src,
    input  logic         y_ready
);

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [N-1:0]   y_q, y_d;
    logic           src_q, src_d;

    logic           free_c;
    logic           grant_c;
    logic           gid_c;
    logic [N-1:0]   win_data_c;

    mux_arbiter_mux2 #(
        .W (N)
    ) u_data_mux (
        .d0_i  (a_data),
        .d1_i  (b_data),
        .sel_i (gid_c),
        .y_o   (win_data_c)
    );

    // Reset value of last_q is B so that A takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SRC_B;
            y_q     <= '0;
            src_q   <= SRC_A;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            y_q     <= y_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        y_d     = y_q;
        src_d   = src_q;
        a_ready = 1'b0;
        b_ready = 1'b0;

        free_c  = (state_q == IDLE) || y_ready;
        gid_c   = pick_src(a_valid, b_valid, last_q);
        // Readies are forced low while reset is held.
        grant_c = rst_n && free_c && (a_valid || b_valid);

        if (grant_c) begin
            a_ready = (gid_c == SRC_A);
            b_ready = (gid_c == SRC_B);
            y_d     = win_data_c;
            src_d   = gid_c;
            last_d  = gid_c;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (y_ready && !grant_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign y_valid = (state_q == HOLD);
    assign y       = y_q;
    assign y_src   = src_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and randomized checks for mux_arbiter with a small reference model.
module tb_mux_arbiter;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         a_valid, b_valid, y_ready;
    logic [N-1:0] a_data, b_data;
    logic         a_ready, b_ready, y_valid, y_src;
    logic [N-1:0] y;

    int n_tests = 0;
    int n_fail  = 0;

    mux_arbiter #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y       (y),
        .y_src   (y_src),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ready outputs must never both be high.
    always @(negedge clk) begin
        check("ready_mutex", 32'(a_ready & b_ready), 32'd0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       m_state, m_last, m_src, free, g, gid;
        logic [N-1:0] m_y;

        rst_n   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 4'h7;
        b_data  = 4'h8;
        y_ready = 1'b1;

        // Reset state, with requesters active during reset.
        #12;
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_y_src", 32'(y_src), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);

        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b1;
        next_cycle();

        // Single A transfer, then buffer drains to IDLE.
        a_valid = 1'b1;
        a_data  = 4'h5;
        #1;
        check("single_a_ready", 32'(a_ready), 32'd1);
        check("single_b_ready", 32'(b_ready), 32'd0);
        next_cycle();
        a_valid = 1'b0;
        check("single_y_valid", 32'(y_valid), 32'd1);
        check("single_y", 32'(y), 32'h5);
        check("single_y_src", 32'(y_src), 32'd0);
        next_cycle();
        check("drain_y_valid", 32'(y_valid), 32'd0);
        check("drain_y_hold", 32'(y), 32'h5);

        // Back-to-back ties from reset alternate A,B,A,B.
        pulse_reset();
        next_cycle();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 4'h1;
        b_data  = 4'h2;
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_a_ready", 32'(a_ready), 32'((i % 2) == 0));
            check("alt_b_ready", 32'(b_ready), 32'((i % 2) == 1));
            next_cycle();
            check("alt_y_valid", 32'(y_valid), 32'd1);
            check("alt_y", 32'(y), ((i % 2) == 0) ? 32'h1 : 32'h2);
            check("alt_y_src", 32'(y_src), 32'(i % 2));
        end

        // Stall: held word stays put and B is not readied until y_ready.
        b_valid = 1'b0;
        a_data  = 4'h3;
        next_cycle();
        check("stall_setup_y", 32'(y), 32'h3);
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 4'h9;
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_b_ready", 32'(b_ready), 32'd0);
            next_cycle();
            check("stall_y", 32'(y), 32'h3);
            check("stall_y_valid", 32'(y_valid), 32'd1);
        end
        y_ready = 1'b1;
        #1;
        check("unstall_b_ready", 32'(b_ready), 32'd1);
        next_cycle();
        b_valid = 1'b0;
        check("unstall_y", 32'(y), 32'h9);
        check("unstall_y_src", 32'(y_src), 32'd1);

        // Async reset mid-HOLD; A had been served last, reset must make A win the tie.
        a_valid = 1'b1;
        a_data  = 4'hA;
        next_cycle();
        a_valid = 1'b0;
        y_ready = 1'b0;
        check("hold_a_y", 32'(y), 32'hA);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y_valid", 32'(y_valid), 32'd0);
        check("async_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 4'h1;
        b_data  = 4'h2;
        y_ready = 1'b1;
        #1;
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        next_cycle();
        check("post_rst_y", 32'(y), 32'h1);
        check("post_rst_src", 32'(y_src), 32'd0);

        // Random traffic against a reference model.
        pulse_reset();
        next_cycle();
        m_state = 1'b0;
        m_last  = 1'b1;
        m_y     = '0;
        m_src   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            y_ready = ($urandom_range(0, 3) != 0);
            a_data  = N'($urandom);
            b_data  = N'($urandom);
            #1;
            free = !m_state || y_ready;
            g    = free && (a_valid || b_valid);
            gid  = (a_valid && b_valid) ? ~m_last : b_valid;
            check("rnd_a_ready", 32'(a_ready), 32'(g && !gid));
            check("rnd_b_ready", 32'(b_ready), 32'(g && gid));
            next_cycle();
            if (g) begin
                m_y     = gid ? b_data : a_data;
                m_src   = gid;
                m_last  = gid;
                m_state = 1'b1;
            end else if (m_state && y_ready) begin
                m_state = 1'b0;
            end
            check("rnd_y_valid", 32'(y_valid), 32'(m_state));
            check("rnd_y", 32'(y), 32'(m_y));
            check("rnd_y_src", 32'(y_src), 32'(m_src));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
